// File: rtl/ddr_target_rx_pkg.sv
// Shared encodings for the HDR-DDR target receive path: FSM states, word
// preambles, broadcast address, CRC token, CRC-5 polynomial and parity helper.
package ddr_target_rx_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PREAMBLE  = 3'd1;
  localparam logic [2:0] ST_PAYLOAD   = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_CRC_TOKEN = 3'd4;
  localparam logic [2:0] ST_CRC_VALUE = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  // Preambles are written {bit0, bit1}; the command preamble doubles as the CRC preamble.
  localparam logic [1:0] PRE_CMD      = 2'b01;
  localparam logic [1:0] PRE_DATA     = 2'b10;
  localparam logic [1:0] PRE_DATA_ALT = 2'b11;

  localparam logic [6:0] BCAST_ADDR   = 7'h7E;
  localparam logic [3:0] CRC_TOKEN    = 4'hC;
  localparam logic [4:0] CRC5_POLY    = 5'b00101;

  // Returns {P1, P0}: P1 over the odd payload bits, P0 over the even bits, inverted.
  function automatic logic [1:0] calc_parity(input logic [15:0] word);
    calc_parity = {^(word & 16'hAAAA), ~(^(word & 16'h5555))};
  endfunction

endpackage

// File: rtl/ddr_crc5.sv
// Serial CRC-5 (x^5 + x^2 + 1), MSB-first, reloaded with the seed on clear.
module ddr_crc5
  import ddr_target_rx_pkg::*;
(
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_clear,
  input  logic [4:0] i_seed,
  input  logic       i_bit_en,
  input  logic       i_bit_in,
  output logic [4:0] o_crc
);

  logic fb_s;

  assign fb_s = o_crc[4] ^ i_bit_in;

  // CRC shift register: seed on reset/clear, one LFSR step per enabled bit.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      o_crc <= i_seed;
    end else if (i_clear) begin
      o_crc <= i_seed;
    end else if (i_bit_en) begin
      o_crc <= {o_crc[3:0], 1'b0} ^ (fb_s ? CRC5_POLY : 5'b00000);
    end else begin
      o_crc <= o_crc;
    end
  end

endmodule

// File: rtl/ddr_target_rx.sv
// HDR-DDR target receiver: frames command/data/CRC words from SCL edge pulses.
// Define DDR_RX_CRC_CHECK_EN to accumulate and check the CRC-5 of data payloads.
module ddr_target_rx
  import ddr_target_rx_pkg::*;
#(
  parameter logic [4:0] CRC5_SEED = 5'h1F
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_enable,
  input  logic       i_scl_pos_edge,
  input  logic       i_scl_neg_edge,
  input  logic       i_sda,
  input  logic       i_restart_det,
  input  logic       i_exit_det,
  input  logic [6:0] i_own_addr,
  output logic       o_sda_drive_en,
  output logic       o_sda_drive_val,
  output logic       o_cmd_valid,
  output logic       o_cmd_rnw,
  output logic [6:0] o_cmd_code,
  output logic [6:0] o_cmd_addr,
  output logic       o_data_valid,
  output logic [15:0] o_data,
  output logic       o_crc_valid,
  output logic       o_crc_err,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  logic [2:0]  state_r;
  logic [4:0]  bit_cnt_r;
  logic [15:0] shift_r;
  logic        pre0_r;
  logic        p1_r;
  logic        expect_cmd_r;
  logic        ack_pend_r;
  logic        edge_s;
  logic        run_s;
  logic [1:0]  pre_s;
  logic        addressed_s;

  assign edge_s      = i_scl_pos_edge | i_scl_neg_edge;
  assign run_s       = i_enable & ~i_exit_det & ~i_restart_det;
  assign pre_s       = {pre0_r, i_sda};
  assign addressed_s = (shift_r[7:1] == i_own_addr) || (shift_r[7:1] == BCAST_ADDR);
  assign o_busy      = (state_r != ST_IDLE);

`ifdef DDR_RX_CRC_CHECK_EN
  logic [4:0] crc_s;
  logic       crc_clr_s;
  logic       crc_en_s;

  assign crc_clr_s = run_s & edge_s & (state_r == ST_PREAMBLE) & expect_cmd_r & (bit_cnt_r == 5'd0);
  assign crc_en_s  = run_s & edge_s & (state_r == ST_PAYLOAD) & ~expect_cmd_r;

  ddr_crc5 u_crc5 (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .i_clear   (crc_clr_s),
    .i_seed    (CRC5_SEED),
    .i_bit_en  (crc_en_s),
    .i_bit_in  (i_sda),
    .o_crc     (crc_s)
  );
`else
  logic unused_seed_s;
  assign unused_seed_s = ^CRC5_SEED;
`endif

  // Word framing FSM with registered command/data/status outputs.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state_r         <= ST_IDLE;
      bit_cnt_r       <= 5'd0;
      shift_r         <= 16'h0000;
      pre0_r          <= 1'b0;
      p1_r            <= 1'b0;
      expect_cmd_r    <= 1'b1;
      ack_pend_r      <= 1'b0;
      o_sda_drive_en  <= 1'b0;
      o_sda_drive_val <= 1'b0;
      o_cmd_valid     <= 1'b0;
      o_cmd_rnw       <= 1'b0;
      o_cmd_code      <= 7'h00;
      o_cmd_addr      <= 7'h00;
      o_data_valid    <= 1'b0;
      o_data          <= 16'h0000;
      o_crc_valid     <= 1'b0;
      o_crc_err       <= 1'b0;
      o_parity_err    <= 1'b0;
      o_frame_err     <= 1'b0;
    end else begin
      o_sda_drive_val <= 1'b0;
      o_cmd_valid     <= 1'b0;
      o_data_valid    <= 1'b0;
      o_crc_valid     <= 1'b0;
      o_crc_err       <= 1'b0;
      o_parity_err    <= 1'b0;
      o_frame_err     <= 1'b0;
      if (i_exit_det || !i_enable) begin
        state_r        <= ST_IDLE;
        bit_cnt_r      <= 5'd0;
        ack_pend_r     <= 1'b0;
        o_sda_drive_en <= 1'b0;
      end else if (i_restart_det) begin
        state_r        <= ST_PREAMBLE;
        bit_cnt_r      <= 5'd0;
        expect_cmd_r   <= 1'b1;
        ack_pend_r     <= 1'b0;
        o_sda_drive_en <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r      <= ST_PREAMBLE;
            bit_cnt_r    <= 5'd0;
            expect_cmd_r <= 1'b1;
          end
          ST_PREAMBLE: begin
            if (edge_s) begin
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd0) begin
                pre0_r <= i_sda;
                // Only the first data preamble after an addressed write is acknowledged.
                if (!expect_cmd_r && i_sda) begin
                  o_sda_drive_en <= ack_pend_r;
                  ack_pend_r     <= 1'b0;
                end
              end else begin
                o_sda_drive_en <= 1'b0;
                if (expect_cmd_r) begin
                  if (pre_s == PRE_CMD) begin
                    state_r <= ST_PAYLOAD;
                  end else begin
                    o_frame_err <= 1'b1;
                    state_r     <= ST_ERROR;
                  end
                end else if (pre_s == PRE_DATA || pre_s == PRE_DATA_ALT) begin
                  state_r <= ST_PAYLOAD;
                end else if (pre_s == PRE_CMD) begin
                  state_r <= ST_CRC_TOKEN;
                end else begin
                  o_frame_err <= 1'b1;
                  state_r     <= ST_ERROR;
                end
              end
            end
          end
          ST_PAYLOAD: begin
            if (edge_s) begin
              shift_r   <= {shift_r[14:0], i_sda};
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd17) begin
                state_r <= ST_PARITY;
              end
            end
          end
          ST_PARITY: begin
            if (edge_s) begin
              if (bit_cnt_r == 5'd18) begin
                p1_r      <= i_sda;
                bit_cnt_r <= 5'd19;
              end else begin
                bit_cnt_r <= 5'd0;
                if ({p1_r, i_sda} != calc_parity(shift_r)) begin
                  o_parity_err <= 1'b1;
                  state_r      <= ST_ERROR;
                end else if (expect_cmd_r) begin
                  o_cmd_valid  <= 1'b1;
                  o_cmd_rnw    <= shift_r[15];
                  o_cmd_code   <= shift_r[14:8];
                  o_cmd_addr   <= shift_r[7:1];
                  expect_cmd_r <= 1'b0;
                  ack_pend_r   <= addressed_s & ~shift_r[15];
                  // Unaddressed commands park in ERROR silently until restart/exit.
                  if (!addressed_s) begin
                    state_r <= ST_ERROR;
                  end else if (shift_r[15]) begin
                    state_r <= ST_IDLE;
                  end else begin
                    state_r <= ST_PREAMBLE;
                  end
                end else begin
                  o_data_valid <= 1'b1;
                  o_data       <= shift_r;
                  state_r      <= ST_PREAMBLE;
                end
              end
            end
          end
          ST_CRC_TOKEN: begin
            if (edge_s) begin
              shift_r   <= {shift_r[14:0], i_sda};
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd5) begin
                if ({shift_r[2:0], i_sda} == CRC_TOKEN) begin
                  state_r <= ST_CRC_VALUE;
                end else begin
                  o_frame_err <= 1'b1;
                  state_r     <= ST_ERROR;
                end
              end
            end
          end
          ST_CRC_VALUE: begin
            if (edge_s) begin
              shift_r   <= {shift_r[14:0], i_sda};
              bit_cnt_r <= bit_cnt_r + 5'd1;
              if (bit_cnt_r == 5'd10) begin
                o_crc_valid <= 1'b1;
`ifdef DDR_RX_CRC_CHECK_EN
                o_crc_err   <= ({shift_r[3:0], i_sda} != crc_s);
`else
                o_crc_err   <= 1'b0;
`endif
                bit_cnt_r   <= 5'd0;
                state_r     <= ST_IDLE;
              end
            end
          end
          ST_ERROR: begin
            state_r <= ST_ERROR;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_target_rx.sv
// Directed self-checking bench for ddr_target_rx (CRC expectation follows DDR_RX_CRC_CHECK_EN).
module tb_ddr_target_rx;

  logic        clk = 1'b0;
  logic        i_sys_rst, i_enable, i_scl_pos_edge, i_scl_neg_edge, i_sda;
  logic        i_restart_det, i_exit_det;
  logic [6:0]  i_own_addr;
  logic        o_sda_drive_en, o_sda_drive_val, o_cmd_valid, o_cmd_rnw;
  logic [6:0]  o_cmd_code, o_cmd_addr;
  logic        o_data_valid;
  logic [15:0] o_data;
  logic        o_crc_valid, o_crc_err, o_parity_err, o_frame_err, o_busy;

  int checks   = 0;
  int failures = 0;
  int n_cmd = 0, n_data = 0, n_crc = 0, n_par = 0, n_frame = 0, n_drive = 0;
  logic pos_sel = 1'b1;

`ifdef DDR_RX_CRC_CHECK_EN
  localparam logic EXP_BAD_CRC_ERR = 1'b1;
`else
  localparam logic EXP_BAD_CRC_ERR = 1'b0;
`endif

  // Hand-derived words: {preamble bit0,bit1, payload, P1,P0}
  localparam logic [19:0] W_CMD_WR    = {2'b01, 16'h0054, 2'b00};
  localparam logic [19:0] W_DATA_ACK  = {2'b10, 16'hA5A5, 2'b01};
  localparam logic [19:0] W_DATA_BADP = {2'b10, 16'hA5A5, 2'b00};
  localparam logic [19:0] W_DATA_NACK = {2'b11, 16'hA5A5, 2'b01};
  localparam logic [19:0] W_CMD_OTHER = {2'b01, 16'h002A, 2'b11};
  localparam logic [19:0] W_CMD_RD    = {2'b01, 16'h8554, 2'b10};
  localparam logic [19:0] W_CRC_GOOD  = {9'h000, 2'b01, 4'hC, 5'h03};
  localparam logic [19:0] W_CRC_BAD   = {9'h000, 2'b01, 4'hC, 5'h02};

  ddr_target_rx dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (i_sys_rst),
    .i_enable        (i_enable),
    .i_scl_pos_edge  (i_scl_pos_edge),
    .i_scl_neg_edge  (i_scl_neg_edge),
    .i_sda           (i_sda),
    .i_restart_det   (i_restart_det),
    .i_exit_det      (i_exit_det),
    .i_own_addr      (i_own_addr),
    .o_sda_drive_en  (o_sda_drive_en),
    .o_sda_drive_val (o_sda_drive_val),
    .o_cmd_valid     (o_cmd_valid),
    .o_cmd_rnw       (o_cmd_rnw),
    .o_cmd_code      (o_cmd_code),
    .o_cmd_addr      (o_cmd_addr),
    .o_data_valid    (o_data_valid),
    .o_data          (o_data),
    .o_crc_valid     (o_crc_valid),
    .o_crc_err       (o_crc_err),
    .o_parity_err    (o_parity_err),
    .o_frame_err     (o_frame_err),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (i_sys_rst === 1'b1) begin
      n_cmd   <= n_cmd   + int'(o_cmd_valid === 1'b1);
      n_data  <= n_data  + int'(o_data_valid === 1'b1);
      n_crc   <= n_crc   + int'(o_crc_valid === 1'b1);
      n_par   <= n_par   + int'(o_parity_err === 1'b1);
      n_frame <= n_frame + int'(o_frame_err === 1'b1);
      n_drive <= n_drive + int'(o_sda_drive_en === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic rs);
    @(negedge clk);
    i_sda = b;
    i_restart_det = rs;
    if (pos_sel) i_scl_pos_edge = 1'b1;
    else         i_scl_neg_edge = 1'b1;
    pos_sel = ~pos_sel;
    @(negedge clk);
    i_scl_pos_edge = 1'b0;
    i_scl_neg_edge = 1'b0;
    i_restart_det  = 1'b0;
  endtask

  task automatic send_range(input logic [19:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i], 1'b0);
  endtask

  task automatic pulse_restart();
    @(negedge clk); i_restart_det = 1'b1;
    @(negedge clk); i_restart_det = 1'b0;
  endtask

  task automatic pulse_exit();
    @(negedge clk); i_exit_det = 1'b1;
    @(negedge clk); i_exit_det = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    i_sys_rst = 1'b0; i_enable = 1'b0; i_scl_pos_edge = 1'b0; i_scl_neg_edge = 1'b0;
    i_sda = 1'b1; i_restart_det = 1'b0; i_exit_det = 1'b0; i_own_addr = 7'h2A;
    idle(3);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_pulses", 32'({o_cmd_valid, o_data_valid, o_crc_valid, o_crc_err, o_parity_err, o_frame_err}), 32'h0);
    check("rst_cmd_fields", 32'({o_cmd_rnw, o_cmd_code, o_cmd_addr}), 32'h0);
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_drive", 32'({o_sda_drive_en, o_sda_drive_val}), 32'h0);

    @(negedge clk); i_sys_rst = 1'b1; i_enable = 1'b1;
    idle(2);
    check("enable_busy", 32'(o_busy), 32'h1);

    // Addressed write, ACKed data word, good CRC.
    send_range(W_CMD_WR, 19, 0);
    check("cmd_valid", 32'(o_cmd_valid), 32'h1);
    check("cmd_fields", 32'({o_cmd_rnw, o_cmd_code, o_cmd_addr}), 32'h0002A);
    send_range(W_DATA_ACK, 19, 19);
    check("ack_drive_en", 32'(o_sda_drive_en), 32'h1);
    check("ack_drive_val", 32'(o_sda_drive_val), 32'h0);
    send_range(W_DATA_ACK, 18, 18);
    check("ack_release", 32'(o_sda_drive_en), 32'h0);
    send_range(W_DATA_ACK, 17, 0);
    check("data_valid", 32'(o_data_valid), 32'h1);
    check("data_value", 32'(o_data), 32'hA5A5);
    send_range(W_CRC_GOOD, 10, 0);
    check("crc_valid_good", 32'(o_crc_valid), 32'h1);
    check("crc_err_good", 32'(o_crc_err), 32'h0);
    check("crc_end_idle", 32'(o_busy), 32'h0);
    idle(2);

    // Same transfer, CRC LSB flipped.
    send_range(W_CMD_WR, 19, 0);
    send_range(W_DATA_ACK, 19, 0);
    send_range(W_CRC_BAD, 10, 0);
    check("crc_valid_bad", 32'(o_crc_valid), 32'h1);
    check("crc_err_bad", 32'(o_crc_err), 32'(EXP_BAD_CRC_ERR));
    idle(2);

    // Parity error parks in ERROR until restart.
    send_range(W_CMD_WR, 19, 0);
    send_range(W_DATA_BADP, 19, 0);
    check("parity_err", 32'(o_parity_err), 32'h1);
    check("parity_no_data", 32'(o_data_valid), 32'h0);
    send_range(W_DATA_NACK, 19, 0);
    check("error_busy", 32'(o_busy), 32'h1);
    pulse_restart();
    send_range(W_CMD_WR, 19, 0);
    check("restart_cmd", 32'(o_cmd_valid), 32'h1);
    idle(2);
    check("n_data_after_err", 32'(n_data), 32'd2);

    // Restart coincident with bit 10 of a data word.
    send_range(W_DATA_ACK, 19, 10);
    send_bit(W_DATA_ACK[9], 1'b1);
    send_range(W_CMD_WR, 19, 0);
    check("cmd_after_abort", 32'(o_cmd_valid), 32'h1);
    idle(2);
    check("n_data_abort", 32'(n_data), 32'd2);

    // Command to another target: no ACK, no data.
    pulse_restart();
    send_range(W_CMD_OTHER, 19, 0);
    check("other_cmd_valid", 32'(o_cmd_valid), 32'h1);
    check("other_cmd_addr", 32'(o_cmd_addr), 32'h15);
    send_range(W_DATA_NACK, 19, 0);
    idle(2);
    check("n_data_other", 32'(n_data), 32'd2);
    check("n_drive_total", 32'(n_drive), 32'd8);

    // Bad command preamble, then exit.
    pulse_restart();
    send_range({2'b10, 18'h0}, 19, 18);
    check("frame_err", 32'(o_frame_err), 32'h1);
    pulse_exit();
    check("exit_idle", 32'(o_busy), 32'h0);

    // Addressed read returns to IDLE.
    idle(1);
    send_range(W_CMD_RD, 19, 0);
    check("rd_cmd_valid", 32'(o_cmd_valid), 32'h1);
    check("rd_cmd_fields", 32'({o_cmd_rnw, o_cmd_code, o_cmd_addr}), 32'({1'b1, 7'h05, 7'h2A}));
    check("rd_idle", 32'(o_busy), 32'h0);

    @(negedge clk); i_enable = 1'b0;
    idle(2);
    check("disable_idle", 32'(o_busy), 32'h0);
    check("n_cmd_total", 32'(n_cmd), 32'd7);
    check("n_crc_total", 32'(n_crc), 32'd2);
    check("n_par_total", 32'(n_par), 32'd1);
    check("n_frame_total", 32'(n_frame), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
